push_btn_debouncer: RTL and testbench
=====================================

// Module: push_btn_debouncer
// PURPOSE
//  Four-channel debouncer that sits directly upstream of the push-button bank. It takes raw,
//  bouncing contact levels raw0..raw3 and drives clean levels btn0..btn3, which feed the
//  bank's btn0..btn3 inputs. The debounce threshold is runtime-programmable over the standard
//  12-bit inst/inst_en device bus: opcode in [11:8], immediate in [7:0].
// PARAMETERS
//  TickDiv        default 1     clock cycles per debounce tick (1..65535); 1 = tick every cycle
//  ResetThreshold default 8'd4  threshold loaded on reset; must be nonzero
// PORTS
//  clock      in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high; dominates every other input
//  inst       in   12  {opcode[3:0], imm[7:0]}
//  inst_en    in   1   inst is executed on a rising edge only while inst_en=1
//  raw0..raw3 in   1   raw contact levels, 1 = pressed; may be asynchronous/bouncing
//  btn0..btn3 out  1   debounced levels, registered
//  threshold  out  8   current threshold register
//  error      out  1   1 = device in Error state
// BEHAVIOUR
//  Reset: btn0..3=0; all counters=0; threshold=ResetThreshold; tick prescaler=0;
//   error=0; state=Ready.
//  Opcodes, executed only in Ready with inst_en=1; each takes 1 cycle:
//   NOP 4'h0: no effect.
//   LDT 4'h1: threshold<=imm; all channel counters<=0; prescaler<=0; btn outputs unchanged.
//    imm==0 is illegal: threshold unchanged, state->Error.
//   CLR 4'h2: btn0..3<=0; counters<=0; prescaler<=0.
//   Any other opcode: state->Error, no other effect.
//  FSM: Ready -(illegal opcode or LDT imm=0)-> Error; Error -(reset)-> Ready only.
//   In Error, inst is ignored, but debouncing continues with the current threshold.
//   error=1 from the edge on which the illegal instruction is accepted.
//  Tick: prescaler counts 0..TickDiv-1. A tick occurs on the edge where the count is
//   TickDiv-1; the count wraps to 0 on that edge. With TickDiv=1, every edge is a tick.
//  Per channel i: cnt_i is 8 bits; s_i is the sampled raw level. On each tick:
//   s_i==btn_i                          -> cnt_i<=0
//   s_i!=btn_i and cnt_i==threshold-1   -> btn_i<=s_i; cnt_i<=0
//   otherwise                           -> cnt_i<=cnt_i+1  (never exceeds threshold-1)
//   Net effect: btn_i changes on the T-th consecutive mismatching tick (T = threshold).
//   Any matching tick in between (a bounce) restarts the count from 0.
//  Latency (TickDiv=1): raw is stable from edge k; btn changes on edge k+T-1 and is
//   visible after that edge. With T=1, btn follows raw one cycle later.
//  Simultaneous events: an instruction and a tick on the same edge -> the instruction's
//   counter and output writes win over the tick update. Channels are independent; all four
//   may change on the same edge.
//  Reset mid-count discards partial counts. LDT mid-count restarts every channel's count.
// CONFIGURATION
//  PUSH_BTN_DEBOUNCER_SYNC_EN defined: each raw_i passes through a 2-flop synchronizer
//   (reset to 0) before use, so s_i = synchronizer output. All latencies grow by 2 cycles.
//  Not defined: s_i = raw_i directly. The caller guarantees raw inputs are synchronous.
// TESTING
//  1 reset; raw0=1 held, TickDiv=1, T=4 -> btn0=0 for 3 edges, btn0=1 after the 4th edge;
//    threshold=8'h04, error=0.
//  2 bounce: raw1 toggles 1,0,1,0 on successive cycles, then holds 1 -> btn1 stays 0 until
//    4 stable cycles, then btn1=1.
//  3 inst={4'h1,8'h02} -> threshold=2; next raw2 press -> btn2=1 after 2 edges;
//    a release is debounced the same way.
//  4 inst={4'h1,8'h00}, then {4'hB,8'hAE} -> error=1, threshold unchanged; a later LDT 8'h07
//    is ignored; raw3 is still debounced with the old T; reset -> error=0, threshold=4.
//  5 all raw=1 -> all btn=1 on the same edge; then CLR with raw still 1 -> all btn=0 next
//    edge; all btn=1 again T edges later.
//  6 TickDiv=3, T=2: raw0 held high -> btn0 rises on the 2nd tick, 4-6 cycles after the
//    change depending on prescaler phase. With SYNC_EN defined, scenario 1 -> rise after
//    the 6th edge.

Source files
------------

// File: rtl/push_btn_debouncer.sv
// push_btn_debouncer: four-channel push-button debouncer with a runtime
// programmable threshold, loaded over the 12-bit inst/inst_en device bus.
// Optional build macro PUSH_BTN_DEBOUNCER_SYNC_EN adds a 2-flop synchronizer
// on every raw input; without it the raw inputs are used as-is.
module push_btn_debouncer #(
  parameter int unsigned TickDiv        = 1,
  parameter logic [7:0]  ResetThreshold = 8'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  input  logic        raw0,
  input  logic        raw1,
  input  logic        raw2,
  input  logic        raw3,
  output logic        btn0,
  output logic        btn1,
  output logic        btn2,
  output logic        btn3,
  output logic [7:0]  threshold,
  output logic        error
);

  localparam logic [15:0] PrescLast = 16'(TickDiv - 1);
  localparam logic [3:0]  OpNop     = 4'h0;
  localparam logic [3:0]  OpLdt     = 4'h1;
  localparam logic [3:0]  OpClr     = 4'h2;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_ERROR = 1'b1
  } state_t;

  state_t      state_q;
  logic        error_q;
  logic [7:0]  thr_q;
  logic [15:0] presc_q;
  logic [15:0] presc_d;

  logic [3:0]  raw_vec;
  logic [3:0]  s_vec;
  logic [3:0]  btn_vec;

  logic        inst_go;
  logic [3:0]  op;
  logic [7:0]  imm;
  logic        ldt_ok;
  logic        clr_hit;
  logic        bad_inst;
  logic        restart;
  logic        tick;
  logic [7:0]  thr_m1;

  assign raw_vec = {raw3, raw2, raw1, raw0};

`ifdef PUSH_BTN_DEBOUNCER_SYNC_EN
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Two-stage synchronizer for the possibly asynchronous contact levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
    end
  end

  assign s_vec = sync2_q;
`else
  assign s_vec = raw_vec;
`endif

  // Instruction decode; only accepted while Ready.
  always_comb begin
    op       = inst[11:8];
    imm      = inst[7:0];
    inst_go  = inst_en && (state_q == ST_READY);
    ldt_ok   = 1'b0;
    clr_hit  = 1'b0;
    bad_inst = 1'b0;
    if (inst_go) begin
      case (op)
        OpNop:   ;
        OpLdt:   if (imm == 8'd0) bad_inst = 1'b1; else ldt_ok = 1'b1;
        OpClr:   clr_hit = 1'b1;
        default: bad_inst = 1'b1;
      endcase
    end
  end

  // An accepted LDT or CLR restarts every count and the tick phase.
  assign restart = ldt_ok || clr_hit;
  assign tick    = (presc_q == PrescLast);
  assign thr_m1  = thr_q - 8'd1;

  // Prescaler next value: instruction restart beats the normal wrap/increment.
  always_comb begin
    presc_d = presc_q + 16'd1;
    if (restart || tick) presc_d = 16'd0;
  end

  // Control FSM with registered error flag, threshold and prescaler.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_READY;
      error_q <= 1'b0;
      thr_q   <= ResetThreshold;
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
      if (ldt_ok) thr_q <= imm;
      if (bad_inst) begin
        state_q <= ST_ERROR;
        error_q <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;
      logic       btn_q;
      logic       btn_d;

      // Per-channel debounce step; instruction writes take priority over the tick.
      always_comb begin
        cnt_d = cnt_q;
        btn_d = btn_q;
        if (restart) begin
          cnt_d = 8'd0;
          if (clr_hit) btn_d = 1'b0;
        end else if (tick) begin
          if (s_vec[gi] == btn_q) begin
            cnt_d = 8'd0;
          end else if (cnt_q == thr_m1) begin
            btn_d = s_vec[gi];
            cnt_d = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      // Channel state registers.
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q <= 8'd0;
          btn_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          btn_q <= btn_d;
        end
      end

      assign btn_vec[gi] = btn_q;
    end
  endgenerate

  assign btn0      = btn_vec[0];
  assign btn1      = btn_vec[1];
  assign btn2      = btn_vec[2];
  assign btn3      = btn_vec[3];
  assign threshold = thr_q;
  assign error     = error_q;

endmodule

// File: tb/tb_push_btn_debouncer.sv
// Directed testbench for push_btn_debouncer: main instance (TickDiv=1, T=4)
// plus a second instance with TickDiv=3, T=2 for prescaler timing.
module tb_push_btn_debouncer;

`ifdef PUSH_BTN_DEBOUNCER_SYNC_EN
  localparam int SL = 2;
  localparam int DL = 8;
`else
  localparam int SL = 0;
  localparam int DL = 5;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] inst = 12'h000;
  logic        inst_en = 1'b0;
  logic        raw0 = 1'b0, raw1 = 1'b0, raw2 = 1'b0, raw3 = 1'b0;
  logic        btn0, btn1, btn2, btn3;
  logic [7:0]  threshold;
  logic        error;

  logic        d_raw0 = 1'b0;
  logic        d_btn0, d_btn1, d_btn2, d_btn3;
  logic [7:0]  d_threshold;
  logic        d_error;

  int checks = 0;
  int failures = 0;

  push_btn_debouncer dut (
    .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
    .raw0(raw0), .raw1(raw1), .raw2(raw2), .raw3(raw3),
    .btn0(btn0), .btn1(btn1), .btn2(btn2), .btn3(btn3),
    .threshold(threshold), .error(error)
  );

  push_btn_debouncer #(.TickDiv(3), .ResetThreshold(8'd2)) u_div (
    .clock(clock), .reset(reset), .inst(12'h000), .inst_en(1'b0),
    .raw0(d_raw0), .raw1(1'b0), .raw2(1'b0), .raw3(1'b0),
    .btn0(d_btn0), .btn1(d_btn1), .btn2(d_btn2), .btn3(d_btn3),
    .threshold(d_threshold), .error(d_error)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic exec(input logic [3:0] op, input logic [7:0] imm);
    inst = {op, imm};
    inst_en = 1'b1;
    step(1);
    inst_en = 1'b0;
    inst = 12'h000;
    $display("INST op=%h imm=%h -> threshold=%h error=%b", op, imm, threshold, error);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    checks++;
    if ({btn3, btn2, btn1, btn0} !== 4'b0000 || threshold !== 8'h04 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: btn=%b thr=%h err=%b, required btn=0000 thr=04 err=0",
               {btn3, btn2, btn1, btn0}, threshold, error);
    end
    reset = 1'b0;
    step(1);
    $display("RESET btn=%b thr=%h err=%b", {btn3, btn2, btn1, btn0}, threshold, error);
  endtask

  task automatic test_press;
    raw0 = 1'b1;
    for (int i = 0; i < SL + 3; i++) begin
      step(1);
      checks++;
      if (btn0 !== 1'b0) begin
        failures++;
        $display("FAIL press_early edge%0d: btn0=%b, required 0", i + 1, btn0);
      end
    end
    step(1);
    checks++;
    if (btn0 !== 1'b1 || threshold !== 8'h04 || error !== 1'b0) begin
      failures++;
      $display("FAIL press_rise: btn0=%b thr=%h err=%b, required 1 04 0", btn0, threshold, error);
    end
    $display("PRESS raw0=1 -> btn0=%b", btn0);
    raw0 = 1'b0;
    step(SL + 4);
    checks++;
    if (btn0 !== 1'b0) begin
      failures++;
      $display("FAIL press_release: btn0=%b, required 0", btn0);
    end
  endtask

  task automatic test_bounce;
    logic [3:0] pat;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      raw1 = pat[i];
      step(1);
    end
    raw1 = 1'b1;
    checks++;
    if (btn1 !== 1'b0) begin
      failures++;
      $display("FAIL bounce_during: btn1=%b, required 0", btn1);
    end
    for (int i = 0; i < SL + 3; i++) begin
      step(1);
      checks++;
      if (btn1 !== 1'b0) begin
        failures++;
        $display("FAIL bounce_hold edge%0d: btn1=%b, required 0", i + 1, btn1);
      end
    end
    step(1);
    checks++;
    if (btn1 !== 1'b1) begin
      failures++;
      $display("FAIL bounce_rise: btn1=%b, required 1", btn1);
    end
    $display("BOUNCE raw1 1,0,1,0 then 1 -> btn1=%b", btn1);
    raw1 = 1'b0;
    step(SL + 4);
    checks++;
    if (btn1 !== 1'b0) begin
      failures++;
      $display("FAIL bounce_release: btn1=%b, required 0", btn1);
    end
  endtask

  task automatic test_ldt;
    exec(4'h1, 8'h02);
    checks++;
    if (threshold !== 8'h02 || error !== 1'b0) begin
      failures++;
      $display("FAIL ldt_thr: thr=%h err=%b, required 02 0", threshold, error);
    end
    raw2 = 1'b1;
    for (int i = 0; i < SL + 1; i++) begin
      step(1);
      checks++;
      if (btn2 !== 1'b0) begin
        failures++;
        $display("FAIL ldt_press_early: btn2=%b, required 0", btn2);
      end
    end
    step(1);
    checks++;
    if (btn2 !== 1'b1) begin
      failures++;
      $display("FAIL ldt_press_rise: btn2=%b, required 1", btn2);
    end
    raw2 = 1'b0;
    for (int i = 0; i < SL + 1; i++) begin
      step(1);
      checks++;
      if (btn2 !== 1'b1) begin
        failures++;
        $display("FAIL ldt_release_early: btn2=%b, required 1", btn2);
      end
    end
    step(1);
    checks++;
    if (btn2 !== 1'b0) begin
      failures++;
      $display("FAIL ldt_release_fall: btn2=%b, required 0", btn2);
    end
    $display("LDT T=2 press/release on raw2 -> btn2=%b", btn2);
    exec(4'h1, 8'h04);
    checks++;
    if (threshold !== 8'h04) begin
      failures++;
      $display("FAIL ldt_restore: thr=%h, required 04", threshold);
    end
  endtask

  task automatic test_error;
    exec(4'h1, 8'h00);
    checks++;
    if (error !== 1'b1 || threshold !== 8'h04) begin
      failures++;
      $display("FAIL err_ldt_zero: err=%b thr=%h, required 1 04", error, threshold);
    end
    exec(4'hB, 8'hAE);
    exec(4'h1, 8'h07);
    checks++;
    if (error !== 1'b1 || threshold !== 8'h04) begin
      failures++;
      $display("FAIL err_ignore_ldt: err=%b thr=%h, required 1 04", error, threshold);
    end
    raw3 = 1'b1;
    for (int i = 0; i < SL + 3; i++) begin
      step(1);
      checks++;
      if (btn3 !== 1'b0) begin
        failures++;
        $display("FAIL err_debounce_early: btn3=%b, required 0", btn3);
      end
    end
    step(1);
    checks++;
    if (btn3 !== 1'b1) begin
      failures++;
      $display("FAIL err_debounce_rise: btn3=%b, required 1", btn3);
    end
    raw3 = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (error !== 1'b0 || threshold !== 8'h04 || btn3 !== 1'b0) begin
      failures++;
      $display("FAIL err_reset: err=%b thr=%h btn3=%b, required 0 04 0", error, threshold, btn3);
    end
    $display("ERROR recovery -> err=%b thr=%h", error, threshold);
    step(SL + 1);
  endtask

  task automatic test_all_clr;
    {raw3, raw2, raw1, raw0} = 4'b1111;
    step(SL + 3);
    checks++;
    if ({btn3, btn2, btn1, btn0} !== 4'b0000) begin
      failures++;
      $display("FAIL all_early: btn=%b, required 0000", {btn3, btn2, btn1, btn0});
    end
    step(1);
    checks++;
    if ({btn3, btn2, btn1, btn0} !== 4'b1111) begin
      failures++;
      $display("FAIL all_rise: btn=%b, required 1111", {btn3, btn2, btn1, btn0});
    end
    exec(4'h2, 8'h00);
    checks++;
    if ({btn3, btn2, btn1, btn0} !== 4'b0000 || error !== 1'b0) begin
      failures++;
      $display("FAIL clr: btn=%b err=%b, required 0000 0", {btn3, btn2, btn1, btn0}, error);
    end
    step(3);
    checks++;
    if ({btn3, btn2, btn1, btn0} !== 4'b0000) begin
      failures++;
      $display("FAIL clr_hold: btn=%b, required 0000", {btn3, btn2, btn1, btn0});
    end
    step(1);
    checks++;
    if ({btn3, btn2, btn1, btn0} !== 4'b1111) begin
      failures++;
      $display("FAIL clr_rerise: btn=%b, required 1111", {btn3, btn2, btn1, btn0});
    end
    $display("ALL+CLR -> btn=%b", {btn3, btn2, btn1, btn0});
    {raw3, raw2, raw1, raw0} = 4'b0000;
    step(SL + 4);
    checks++;
    if ({btn3, btn2, btn1, btn0} !== 4'b0000) begin
      failures++;
      $display("FAIL all_release: btn=%b, required 0000", {btn3, btn2, btn1, btn0});
    end
  endtask

  task automatic test_midcount_ldt;
    raw0 = 1'b1;
    step(SL + 2);
    exec(4'h1, 8'h04);
    step(3);
    checks++;
    if (btn0 !== 1'b0) begin
      failures++;
      $display("FAIL midcount_restart: btn0=%b, required 0", btn0);
    end
    step(1);
    checks++;
    if (btn0 !== 1'b1) begin
      failures++;
      $display("FAIL midcount_rise: btn0=%b, required 1", btn0);
    end
    $display("MIDCOUNT LDT -> btn0=%b", btn0);
    raw0 = 1'b0;
    step(SL + 4);
  endtask

  task automatic test_tickdiv;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    d_raw0 = 1'b1;
    step(5);
    checks++;
    if (d_btn0 !== 1'b0) begin
      failures++;
      $display("FAIL div_early: btn0=%b, required 0", d_btn0);
    end
    step(1);
    checks++;
    if (d_btn0 !== 1'b1 || d_threshold !== 8'h02) begin
      failures++;
      $display("FAIL div_rise6: btn0=%b thr=%h, required 1 02", d_btn0, d_threshold);
    end
    d_raw0 = 1'b0;
    step(5);
    checks++;
    if (d_btn0 !== 1'b1) begin
      failures++;
      $display("FAIL div_release_early: btn0=%b, required 1", d_btn0);
    end
    step(1);
    checks++;
    if (d_btn0 !== 1'b0) begin
      failures++;
      $display("FAIL div_release: btn0=%b, required 0", d_btn0);
    end
    step(1);
    d_raw0 = 1'b1;
    step(DL - 1);
    checks++;
    if (d_btn0 !== 1'b0) begin
      failures++;
      $display("FAIL div_phase_early: btn0=%b, required 0", d_btn0);
    end
    step(1);
    checks++;
    if (d_btn0 !== 1'b1) begin
      failures++;
      $display("FAIL div_phase_rise: btn0=%b, required 1", d_btn0);
    end
    $display("TICKDIV=3 T=2 -> btn0=%b", d_btn0);
    d_raw0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_ldt();
    test_error();
    test_all_clr();
    test_midcount_ldt();
    test_tickdiv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
